// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the multi-cycle serial adder/subtractor.
// Optional feature macro: SERADD_OVF_EN (adds the signed-overflow output).
package serial_adder_pkg;

  // Controller states: accept operands, ripple one digit per cycle, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operation select encoding on the op input.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_slice.sv
// Combinational DIGIT-bit ripple of full-adder cells. Besides the sum and
// carry-out it exposes the carry into the most significant bit, which the
// top level uses to derive signed overflow on the final digit.
module adder_slice #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  // Ripple the carry from bit 0 upward; c_msb captures the carry entering the top bit.
  always_comb begin
    logic c;
    c     = ci;
    s     = '0;
    c_msb = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing one DIGIT-bit slice per
// clock. Subtraction is done as a + ~b + ~cin, so cout=1 means "no borrow".
// Optional feature macro: SERADD_OVF_EN adds the registered signed-overflow
// output ovf; without it there is no ovf port and no overflow logic.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: in_ready is high only in IDLE, and a, b, cin, op
// are sampled solely on that accepting edge. Output side: out_valid is high
// in DONE with sum/cout/ovf held stable until the edge where out_ready is high;
// out_valid never drops without a completed transfer (except under reset).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  // DIGIT must tile WIDTH exactly; anything else is a configuration error.
  if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;      // b already inverted for subtraction
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             carry_q;
  logic             cout_q;
  logic             out_valid_q;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             slice_cmsb;

  assign dig_a = a_q[cnt_q*DIGIT +: DIGIT];
  assign dig_b = b_q[cnt_q*DIGIT +: DIGIT];

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (dig_a),
    .y     (dig_b),
    .ci    (carry_q),
    .s     (slice_s),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // Merge the current slice result into its digit position; advance the digit index.
  always_comb begin
    sum_d = sum_q;
    sum_d[cnt_q*DIGIT +: DIGIT] = slice_s;
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Controller: latch operands in IDLE, ripple digits in RUN, hold result in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= (op == OP_SUB) ? ~b : b;
            carry_q <= cin ^ (op == OP_SUB);
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_co;
          cnt_q   <= cnt_d;
          if (cnt_q == LAST_DIGIT) begin
            cout_q      <= slice_co;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef SERADD_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it on the final digit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && cnt_q == LAST_DIGIT) begin
      ovf_q <= slice_cmsb ^ slice_co;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_cmsb;
  assign unused_cmsb = slice_cmsb;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: an 8-bit/4-bit-digit instance for directed and
// random operations, and a 3-bit/1-bit-digit instance swept exhaustively.
// Expected results come from integer arithmetic on the operand values.
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset_n;

  // 8-bit instance signals
  logic       in_valid8, in_ready8, cin8, op8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  // 3-bit instance signals
  logic       in_valid3, in_ready3, cin3, op3, out_valid3, out_ready3, cout3;
  logic [2:0] a3, b3, sum3;
`ifdef SERADD_OVF_EN
  logic ovf8, ovf3;
`endif

  int checks = 0;
  int errors = 0;

  // clock / reset block
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
`ifdef SERADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(3), .DIGIT(1)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .a(a3), .b(b3), .cin(cin3), .op(op3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .sum(sum3), .cout(cout3)
`ifdef SERADD_OVF_EN
    , .ovf(ovf3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input int a, input int b, input int cin,
                                input int op, output int s, output int co, output int ov);
    int m, r, sa, sb, rs;
    m  = 1 << w;
    if (op == 0) begin
      r  = a + b + cin;
      co = (r >= m) ? 1 : 0;
    end else begin
      r  = a - b - cin;
      co = (r >= 0) ? 1 : 0;
    end
    s  = (r + 2 * m) % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    rs = (op == 0) ? sa + sb + cin : sa - sb - cin;
    ov = (rs < -(m / 2) || rs > m / 2 - 1) ? 1 : 0;
  endfunction

  // Driver: one operation on the 8-bit instance, optionally holding the result.
  task automatic do_op8(input int a_v, input int b_v, input int cin_v, input int op_v,
                        input int hold, input string tag);
    int es, ec, eo, lat;
    logic [7:0] held;
    model(8, a_v, b_v, cin_v, op_v, es, ec, eo);
    @(negedge clk);
    check({tag, ".in_ready"}, in_ready8, 1);
    a8 = 8'(a_v); b8 = 8'(b_v); cin8 = cin_v[0]; op8 = op_v[0]; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); op8 = 1'($urandom);
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 2);
    check({tag, ".sum"}, sum8, es);
    check({tag, ".cout"}, cout8, ec);
`ifdef SERADD_OVF_EN
    check({tag, ".ovf"}, ovf8, eo);
`endif
    held = sum8;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, out_valid8, 1);
      check({tag, ".hold_sum"}, sum8, held);
      check({tag, ".hold_cout"}, cout8, ec);
      check({tag, ".hold_in_ready"}, in_ready8, 0);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({tag, ".post_in_ready"}, in_ready8, 1);
    check({tag, ".post_out_valid"}, out_valid8, 0);
  endtask

  // Driver: one operation on the 3-bit bit-serial instance.
  task automatic do_op3(input int a_v, input int b_v, input int cin_v, input int op_v);
    int es, ec, eo, lat;
    model(3, a_v, b_v, cin_v, op_v, es, ec, eo);
    @(negedge clk);
    a3 = 3'(a_v); b3 = 3'(b_v); cin3 = cin_v[0]; op3 = op_v[0]; in_valid3 = 1'b1;
    @(posedge clk); #1;
    in_valid3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom);
    lat = 0;
    while (out_valid3 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w3.latency", lat, 3);
    check("w3.sum", sum3, es);
    check("w3.cout", cout3, ec);
`ifdef SERADD_OVF_EN
    check("w3.ovf", ovf3, eo);
`endif
    out_ready3 = 1'b1;
    @(posedge clk); #1;
    out_ready3 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0;
    in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; op3 = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready", in_ready8, 1);
    check("rst.out_valid", out_valid8, 0);
    check("rst.sum", sum8, 0);
    check("rst.cout", cout8, 0);
`ifdef SERADD_OVF_EN
    check("rst.ovf", ovf8, 0);
`endif
    reset_n = 1'b1;

    // Carry across digits
    do_op8(8'hFF, 8'h01, 0, 0, 0, "carry");
    // Subtract with borrow, then without
    do_op8(8'h05, 8'h07, 0, 1, 0, "sub_borrow");
    do_op8(8'h07, 8'h05, 1, 1, 0, "sub_cin");
    // Overflow corner cases
    do_op8(8'h7F, 8'h01, 0, 0, 0, "ovf_add");
    do_op8(8'h80, 8'h01, 0, 1, 0, "ovf_sub");
    do_op8(8'h10, 8'h20, 0, 0, 0, "no_ovf");
    // Backpressure, then back-to-back
    do_op8(8'hA5, 8'h3C, 1, 0, 5, "backpressure");
    do_op8(8'h12, 8'h34, 0, 1, 0, "b2b_0");
    do_op8(8'hC8, 8'h9F, 1, 0, 0, "b2b_1");

    // Reset mid-RUN: first op leaves a nonzero sum, then abort the next one
    do_op8(8'h55, 8'h22, 0, 0, 0, "pre_abort");
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; op8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("abort.out_valid", out_valid8, 0);
    check("abort.sum", sum8, 0);
    check("abort.in_ready", in_ready8, 1);
    @(negedge clk);
    reset_n = 1'b1;
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort.no_result", out_valid8, 0);
    end
    out_ready8 = 1'b0;
    do_op8(8'h3E, 8'h41, 1, 0, 0, "post_abort");

    // Random operations
    for (int i = 0; i < 30; i++) begin
      do_op8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 2), "random");
    end

    // Exhaustive bit-serial sweep on the 3-bit instance
    for (int op = 0; op < 2; op++)
      for (int c = 0; c < 2; c++)
        for (int av = 0; av < 8; av++)
          for (int bv = 0; bv < 8; bv++)
            do_op3(av, bv, c, op);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
